left_shift_iterative: RTL and testbench
=======================================

Name: left_shift_iterative

Overview:
- Multi-cycle logical left shifter of an unsigned N-bit operand by a run-time shift amount.
- Shifts at most STEP bits per clock, trading latency for a narrow shift datapath.
- Valid/ready on both sides; sits in the arithmetic block set as the left-direction, sequential counterpart to the constant right shifters.
- Also reports whether any 1 bit was shifted out (overflow).

Parameters:
- N, 8, operand/result width in bits (N >= 2).
- STEP, 3, maximum bits shifted per clock (1 <= STEP <= N).
- AW, $clog2(N+1), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- up_valid  input  1  operand and amount are valid
- up_ready  output  1  block can accept an operand
- a  input  N  unsigned operand
- amt  input  AW  requested left shift amount
- down_valid  output  1  result is valid
- down_ready  input  1  consumer accepts the result
- res  output  N  a << min(amt, N), zero-filled from the LSB
- ovf  output  1  1 when any 1 bit was shifted past bit N-1

Behaviour:
- Reset: asynchronous, active-high.
  - state=IDLE; res=0; ovf=0; down_valid=0; internal remaining count=0.
  - up_ready=1 whenever state=IDLE, including during reset.
- States: IDLE, SHIFT, DONE. up_ready=(state==IDLE); down_valid=(state==DONE).
- IDLE, on up_valid && up_ready:
  - Load a into res, clear ovf, rem=min(amt, N).
  - If the effective amount is 0, go to DONE; otherwise go to SHIFT.
- SHIFT, each cycle:
  - k=min(rem, STEP); res <= res << k.
  - ovf <= ovf | (OR of the top k bits of res before the shift).
  - rem <= rem - k. Go to DONE when rem-k==0.
- DONE:
  - res and ovf are held stable while down_ready=0.
  - On down_ready, go to IDLE. A new operand is accepted no earlier than the following cycle.
- Latency: operand accepted in cycle t → down_valid in cycle t+1+ceil(min(amt,N)/STEP).
- Throughput: one operation per latency+1 cycles when down_ready is held high.
- Saturation: amt >= N gives res=0, and ovf=1 if a!=0. The amount is clamped to N, never taken modulo N.
- Inputs a and amt are ignored outside the accept cycle. up_valid in SHIFT or DONE is not accepted; upstream must hold it.
- Reset during SHIFT or DONE: the in-flight operation is discarded and no result is emitted.
- down_ready while down_valid=0: no effect.
- Widths: the shift step uses N-bit logical shifts and never sign-extends. rem is AW bits wide.

Decomposition:
- Shared package shift_pkg:
  - typedef enum for IDLE/SHIFT/DONE (shift_state_t).
  - helper function min_u for the amount/step clamps.
- One combinational sub-module, left_shift_step:
  - Parameters N and STEP; inputs value[N-1:0] and k (0..STEP).
  - Outputs value<<k and lost = OR of the bits shifted out.
- The top level holds the FSM, res/ovf/rem registers and the handshake.

Test Plan (N=8, STEP=3):
- a=8'h05, amt=3, accept at t, down_ready=1 → res=8'h28, ovf=0, down_valid only at t+2, up_ready=1 at t+3.
- a=8'hFF, amt=4 → two SHIFT cycles; res=8'hF0, ovf=1, down_valid at t+3.
- a=8'hA5, amt=0 → res=8'hA5, ovf=0, down_valid at t+1 (SHIFT skipped).
- a=8'h81, amt=9 (clamped to 8) → res=8'h00, ovf=1, down_valid at t+4. Also a=8'h00, amt=12 → res=0, ovf=0.
- Backpressure: result 8'h28 with down_ready=0 for 5 cycles → res/ovf stable, down_valid=1, up_ready=0 throughout, and an asserted up_valid is not accepted. Then down_ready=1 for one cycle → IDLE next cycle, and the held up_valid is accepted then.
- rst pulsed mid-SHIFT (a=8'hFF, amt=8) → down_valid=0 and res=0 immediately, without waiting for clk. After release, up_ready=1 and no stale result ever appears.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
// Module : shift_pkg
// Brief  : Shared state encoding and clamp helper for the iterative shifters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    function automatic int unsigned min_u(input int unsigned x, input int unsigned y);
        return (x < y) ? x : y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/left_shift_step.sv
// ============================================================================
// Module : left_shift_step
// Brief  : One combinational left-shift step of up to STEP bits with loss flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module left_shift_step #(
    parameter int N    = 8,
    parameter int STEP = 3,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [N-1:0]  i_value,
    input  logic [KW-1:0] i_k,
    output logic [N-1:0]  o_value,
    output logic          o_lost
);

    localparam logic [N-1:0] c_ones = '1;

    logic [N-1:0] w_keep_mask;

    assign o_value     = i_value << i_k;
    // Bits surviving the shift; everything outside this mask falls off the top.
    assign w_keep_mask = c_ones >> i_k;
    assign o_lost      = |(i_value & ~w_keep_mask);

endmodule

`default_nettype wire

// File: rtl/left_shift_iterative.sv
// ============================================================================
// Module : left_shift_iterative
// Brief  : Multi-cycle logical left shifter, STEP bits per clock, with overflow.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module left_shift_iterative
    import shift_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int STEP = 3,
    localparam int AW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  a,
    input  logic [AW-1:0] amt,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  res,
    output logic          ovf
);

    shift_state_t  r_state;
    logic [N-1:0]  r_res;
    logic          r_ovf;
    logic [AW-1:0] r_rem;

    logic [AW-1:0] w_amt_eff;
    logic [AW-1:0] w_k;
    logic [N-1:0]  w_step_val;
    logic          w_step_lost;

    // Amounts past N saturate rather than wrap.
    assign w_amt_eff = AW'(min_u(32'(amt), 32'(N)));
    assign w_k       = AW'(min_u(32'(r_rem), 32'(STEP)));

    left_shift_step #(
        .N    (N),
        .STEP (STEP),
        .KW   (AW)
    ) u_step (
        .i_value (r_res),
        .i_k     (w_k),
        .o_value (w_step_val),
        .o_lost  (w_step_lost)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_res   <= '0;
            r_ovf   <= 1'b0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (up_valid) begin
                        r_res   <= a;
                        r_ovf   <= 1'b0;
                        r_rem   <= w_amt_eff;
                        r_state <= (w_amt_eff == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    r_res <= w_step_val;
                    r_ovf <= r_ovf | w_step_lost;
                    r_rem <= r_rem - w_k;
                    if (r_rem == w_k) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (down_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign up_ready   = (r_state == IDLE);
    assign down_valid = (r_state == DONE);
    assign res        = r_res;
    assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_left_shift_iterative.sv
// ============================================================================
// Module : tb_left_shift_iterative
// Brief  : Scoreboard bench for left_shift_iterative (N=8, STEP=3).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_left_shift_iterative;

    localparam int N    = 8;
    localparam int STEP = 3;
    localparam int AW   = 4;
    localparam int BOUND = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [N-1:0]  a = '0;
    logic [AW-1:0] amt = '0;
    logic          down_valid;
    logic          down_ready = 1'b0;
    logic [N-1:0]  res;
    logic          ovf;

    typedef struct {
        logic [N-1:0] res;
        logic         ovf;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    left_shift_iterative #(.N(N), .STEP(STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .a          (a),
        .amt        (amt),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .res        (res),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit-by-bit reference: bit i lands at i+eff or is lost off the top.
    function automatic exp_t model(input logic [N-1:0] av, input logic [AW-1:0] am);
        exp_t e;
        int   eff;
        eff   = (int'(am) > N) ? N : int'(am);
        e.lat = 1 + (eff + STEP - 1) / STEP;
        e.res = '0;
        e.ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i + eff < N) e.res[i + eff] = av[i];
            else if (av[i]) e.ovf = 1'b1;
        end
        return e;
    endfunction

    // Called just after a falling edge; returns the cycle whose rising edge accepts.
    task automatic accept_op(input logic [N-1:0] av, input logic [AW-1:0] am,
                             output int t, output bit ok);
        int n;
        a = av; amt = am; up_valid = 1'b1;
        n = 0;
        while (!up_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        ok = up_ready;
        t  = cyc;
        if (ok) sb.push_back(model(av, am));
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    task automatic wait_valid(output int t, output bit ok);
        int n;
        n = 0;
        while (!down_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        ok = down_valid;
        t  = cyc;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0 || res !== '0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: up_ready=%b down_valid=%b res=%h ovf=%b, need 1 0 00 0",
                     up_ready, down_valid, res, ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: up_ready=%b down_valid=%b, need 1 0", up_ready, down_valid);
        end
    endtask

    task automatic test_shift_table;
        logic [N-1:0]  ta[8] = '{8'h05, 8'hFF, 8'hA5, 8'h81, 8'h00, 8'hFF, 8'h01, 8'h80};
        logic [AW-1:0] tm[8] = '{4'd3, 4'd4, 4'd0, 4'd9, 4'd12, 4'd8, 4'd7, 4'd1};
        int   t0, t1;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            accept_op(ta[i], tm[i], t0, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL table_accept[%0d]: up_ready never rose", i);
                continue;
            end
            wait_valid(t1, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL table_timeout[%0d]: down_valid never rose", i);
                continue;
            end
            n_checks++;
            if (res !== e.res || ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL table_result[%0d] a=%h amt=%0d: res=%h ovf=%b, need res=%h ovf=%b",
                         i, ta[i], tm[i], res, ovf, e.res, e.ovf);
            end
            n_checks++;
            if (t1 - t0 !== e.lat) begin
                n_fail++;
                $display("FAIL table_latency[%0d]: got %0d cycles, need %0d", i, t1 - t0, e.lat);
            end
            down_ready = 1'b1;
            @(negedge clk);
            down_ready = 1'b0;
            n_checks++;
            if (up_ready !== 1'b1 || down_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL table_return_idle[%0d]: up_ready=%b down_valid=%b, need 1 0",
                         i, up_ready, down_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        int   t0, t1, t2;
        bit   ok;
        exp_t e;
        accept_op(8'h05, 4'd3, t0, ok);
        wait_valid(t1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_timeout: down_valid never rose");
            return;
        end
        e = sb.pop_front();
        a = 8'h81; amt = 4'd9; up_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (down_valid !== 1'b1 || up_ready !== 1'b0 || res !== e.res || ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: dv=%b ur=%b res=%h ovf=%b, need 1 0 %h %b",
                         i, down_valid, up_ready, res, ovf, e.res, e.ovf);
            end
        end
        down_ready = 1'b1;
        @(negedge clk);
        down_ready = 1'b0;
        n_checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: up_ready=%b down_valid=%b, need 1 0", up_ready, down_valid);
        end
        t2 = cyc;
        sb.push_back(model(8'h81, 4'd9));
        @(negedge clk);
        up_valid = 1'b0;
        n_checks++;
        if (up_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_held_accept: up_ready=%b, need 0", up_ready);
        end
        wait_valid(t1, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || res !== e.res || ovf !== e.ovf || t1 - t2 !== e.lat) begin
            n_fail++;
            $display("FAIL bp_second: ok=%b res=%h ovf=%b lat=%0d, need res=%h ovf=%b lat=%0d",
                     ok, res, ovf, t1 - t2, e.res, e.ovf, e.lat);
        end
        down_ready = 1'b1;
        @(negedge clk);
        down_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int  t0;
        bit  ok;
        bit  stale;
        accept_op(8'hFF, 4'd8, t0, ok);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (down_valid !== 1'b0 || res !== '0 || ovf !== 1'b0 || up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_async: dv=%b res=%h ovf=%b ur=%b, need 0 00 0 1",
                     down_valid, res, ovf, up_ready);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (down_valid !== 1'b0 || up_ready !== 1'b1) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("FAIL rst_mid_stale: result or busy state after reset, stale=%b need 0", stale);
        end
    endtask

    task automatic test_back_to_back;
        int            t0, t1, t_prev, lat_prev;
        bit            ok;
        exp_t          e;
        logic [N-1:0]  av;
        logic [AW-1:0] am;
        t_prev   = -1;
        lat_prev = 0;
        for (int i = 0; i < 20; i++) begin
            av = N'($urandom);
            am = AW'($urandom_range(0, 15));
            accept_op(av, am, t0, ok);
            if (t_prev >= 0) begin
                n_checks++;
                if (t0 - t_prev !== lat_prev + 1) begin
                    n_fail++;
                    $display("FAIL b2b_throughput[%0d]: gap %0d, need %0d", i, t0 - t_prev, lat_prev + 1);
                end
            end
            wait_valid(t1, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || res !== e.res || ovf !== e.ovf || t1 - t0 !== e.lat) begin
                n_fail++;
                $display("FAIL b2b_result[%0d] a=%h amt=%0d: res=%h ovf=%b lat=%0d, need %h %b %0d",
                         i, av, am, res, ovf, t1 - t0, e.res, e.ovf, e.lat);
            end
            t_prev   = t0;
            lat_prev = e.lat;
            down_ready = 1'b1;
            @(negedge clk);
            down_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_shift_table();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
